// File: rtl/md_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface md_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        rd_sel;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] HILO_out;

    modport master (
        output start, md_op, A, B, rd_sel,
        input  busy, HI, LO, HILO_out
    );

    modport slave (
        input  start, md_op, A, B, rd_sel,
        output busy, HI, LO, HILO_out
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; fixed-latency MULT/DIV plus MTHI/MTLO.
// Optional MADD accumulate (md_op=6) is built only when MDU_MADD_EN is defined.
module md_unit #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  bus
);
    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [2:0]       op_q, op_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag, b_mag, b_safe, b_usafe;
    logic [31:0] q_mag, r_mag, sq, sr, uq, ur;

    assign prod_u = {32'b0, a_q} * {32'b0, b_q};
    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});

    // Signed divide through magnitudes so 0x80000000 / -1 wraps to 0x80000000 naturally.
    assign a_mag   = a_q[31] ? (32'd0 - a_q) : a_q;
    assign b_mag   = b_q[31] ? (32'd0 - b_q) : b_q;
    assign b_safe  = (b_q == 32'd0) ? 32'd1 : b_mag;
    assign b_usafe = (b_q == 32'd0) ? 32'd1 : b_q;
    assign q_mag   = a_mag / b_safe;
    assign r_mag   = a_mag % b_safe;
    assign sq      = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
    assign sr      = a_q[31] ? (32'd0 - r_mag) : r_mag;
    assign uq      = a_q / b_usafe;
    assign ur      = a_q % b_usafe;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.md_op)
                        3'd0, 3'd1,
`ifdef MDU_MADD_EN
                        3'd6,
`endif
                        3'd2, 3'd3: begin
                            a_d     = bus.A;
                            b_d     = bus.B;
                            op_d    = bus.md_op;
                            busy_d  = 1'b1;
                            state_d = S_RUN;
                            cnt_d   = (bus.md_op == 3'd2 || bus.md_op == 3'd3)
                                      ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
                        end
                        3'd4:    hi_d = bus.A;
                        3'd5:    lo_d = bus.A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                    case (op_q)
                        3'd0: {hi_d, lo_d} = prod_s;
                        3'd1: {hi_d, lo_d} = prod_u;
                        3'd2: if (b_q != 32'd0) begin
                            hi_d = sr;
                            lo_d = sq;
                        end
                        3'd3: if (b_q != 32'd0) begin
                            hi_d = ur;
                            lo_d = uq;
                        end
`ifdef MDU_MADD_EN
                        3'd6: {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
`endif
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
    assign bus.HILO_out = bus.rd_sel ? hi_q : lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: arithmetic reference model with a per-cycle compare plus directed literals.
module tb_md_unit;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    md_unit_if bus();

    md_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference model: results computed with plain 64-bit arithmetic, applied when the latency expires.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] pa = 32'd0;
    logic [31:0] pb = 32'd0;
    logic [2:0]  pop = 3'd0;
    int          m_left = 0;

    function automatic logic [63:0] md_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] hi,
                                              input logic [31:0] lo);
        int          sa, sb;
        longint      ps;
        logic [63:0] r;
        sa = a;
        sb = b;
        ps = longint'(sa) * longint'(sb);
        r  = {hi, lo};
        case (op)
            3'd0: r = ps;
            3'd1: r = {32'b0, a} * {32'b0, b};
            3'd2: if (b != 32'd0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    r[63:32] = sa % sb;
                    r[31:0]  = sa / sb;
                end
            end
            3'd3: if (b != 32'd0) r = {a % b, a / b};
            3'd6: r = {hi, lo} + ps;
            default: ;
        endcase
        return r;
    endfunction

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            m_left = 0;
        end else if (m_left > 0) begin
            if (m_left == 1) {m_hi, m_lo} = md_result(pop, pa, pb, m_hi, m_lo);
            m_left--;
        end else if (bus.start) begin
            case (bus.md_op)
                3'd0, 3'd1,
`ifdef MDU_MADD_EN
                3'd6,
`endif
                3'd2, 3'd3: begin
                    pop    = bus.md_op;
                    pa     = bus.A;
                    pb     = bus.B;
                    m_left = (bus.md_op == 3'd2 || bus.md_op == 3'd3) ? DIV_LAT : MULT_LAT;
                end
                3'd4:    m_hi = bus.A;
                3'd5:    m_lo = bus.A;
                default: ;
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        chk("cyc_busy", {31'b0, bus.busy}, {31'b0, (m_left > 0)});
        chk("cyc_hi", bus.HI, m_hi);
        chk("cyc_lo", bus.LO, m_lo);
        chk("cyc_hilo_out", bus.HILO_out, bus.rd_sel ? m_hi : m_lo);
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = 32'hDEAD_BEEF;
        bus.B     = 32'hCAFE_F00D;
        $display("op=%0d A=%08h B=%08h -> busy=%0b HI=%08h LO=%08h", op, a, b, bus.busy, bus.HI, bus.LO);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        if (cyc >= 100) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", bus.busy, cyc);
        end
    endtask

    int c;

    initial begin
        bus.start  = 1'b0;
        bus.md_op  = 3'd0;
        bus.A      = 32'd0;
        bus.B      = 32'd0;
        bus.rd_sel = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_hi", bus.HI, 32'd0);
        chk("rst_lo", bus.LO, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        #1;

        drive(3'd0, 32'hFFFF_FFFE, 32'd3);
        wait_idle(c);
        chk("mult_lat", 32'(c), 32'd5);
        chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
        chk("mult_lo", bus.LO, 32'hFFFF_FFFA);
        bus.rd_sel = 1'b1;
        #1;
        chk("mult_hilo_hi", bus.HILO_out, 32'hFFFF_FFFF);
        bus.rd_sel = 1'b0;
        #1;
        chk("mult_hilo_lo", bus.HILO_out, 32'hFFFF_FFFA);

        drive(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle(c);
        chk("div_lat", 32'(c), 32'd10);
        chk("div_lo", bus.LO, 32'hFFFF_FFFD);
        chk("div_hi", bus.HI, 32'hFFFF_FFFF);

        drive(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(c);
        chk("divovf_lo", bus.LO, 32'h8000_0000);
        chk("divovf_hi", bus.HI, 32'd0);

        drive(3'd4, 32'h11, 32'd0);
        chk("mthi_busy", {31'b0, bus.busy}, 32'd0);
        chk("mthi_hi", bus.HI, 32'h11);
        drive(3'd5, 32'h22, 32'd0);
        chk("mtlo_lo", bus.LO, 32'h22);

        drive(3'd3, 32'd7, 32'd0);
        wait_idle(c);
        chk("divz_lat", 32'(c), 32'd10);
        chk("divz_hi", bus.HI, 32'h11);
        chk("divz_lo", bus.LO, 32'h22);

        drive(3'd3, 32'd100, 32'd7);
        wait_idle(c);
        chk("divu_lo", bus.LO, 32'd14);
        chk("divu_hi", bus.HI, 32'd2);

        drive(3'd7, 32'h55, 32'h66);
        chk("op7_busy", {31'b0, bus.busy}, 32'd0);
        chk("op7_hi", bus.HI, 32'd2);
        chk("op7_lo", bus.LO, 32'd14);
`ifndef MDU_MADD_EN
        drive(3'd6, 32'h55, 32'h66);
        chk("op6_busy", {31'b0, bus.busy}, 32'd0);
        chk("op6_lo", bus.LO, 32'd14);
`endif

        drive(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        bus.start = 1'b1;
        bus.md_op = 3'd5;
        bus.A     = 32'h5;
        @(negedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle(c);
        chk("ovl_rest_lat", 32'(c), 32'd3);
        chk("ovl_hi", bus.HI, 32'hFFFF_FFFE);
        chk("ovl_lo", bus.LO, 32'h0000_0001);

        drive(3'd2, 32'd100, 32'd3);
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_busy", {31'b0, bus.busy}, 32'd0);
        chk("rstmid_hi", bus.HI, 32'd0);
        chk("rstmid_lo", bus.LO, 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        #1;
        drive(3'd4, 32'h1234, 32'd0);
        chk("rstrel_hi", bus.HI, 32'h1234);
        repeat (12) @(negedge clk);
        #1;
        chk("rstrel_hold_hi", bus.HI, 32'h1234);
        chk("rstrel_hold_lo", bus.LO, 32'd0);

`ifdef MDU_MADD_EN
        drive(3'd4, 32'd0, 32'd0);
        drive(3'd5, 32'hFFFF_FFFF, 32'd0);
        drive(3'd6, 32'd1, 32'd1);
        wait_idle(c);
        chk("madd_lat", 32'(c), 32'd5);
        chk("madd_hi", bus.HI, 32'd1);
        chk("madd_lo", bus.LO, 32'd0);
`endif

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage. Owns the HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU with fixed latencies and handles MTHI/MTLO.
- Drives the HI/LO read value that EX forwards into the EX/MEM register as the HILO field.
- Exports busy to the hazard unit, which stalls md instructions and mfhi/mflo while the unit is occupied.

Parameters:
- MULT_LAT, 5: cycles busy is held for MULT/MULTU.
- DIV_LAT, 10: cycles busy is held for DIV/DIVU.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (reset=0 resets)
- start  input  1  one-cycle request; qualifies md_op, A, B
- md_op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6=MADD (feature only); 7=reserved
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- rd_sel  input  1  0=LO, 1=HI for the read port
- busy  output  1  registered; high while a mult/div is in flight
- HI  output  32  HI register
- LO  output  32  LO register
- HILO_out  output  32  combinational: rd_sel ? HI : LO

Behaviour:
- Reset (reset=0, any time, asynchronous):
  - state=IDLE, counter=0, busy=0, HI=0, LO=0.
  - Any in-flight operation is aborted with no HI/LO write.
- States:
  - IDLE: accepts start.
  - RUN: counting down.
- Start accepted in IDLE, op 0-3 (or 6 with the feature enabled):
  - The accepting edge latches A, B and op, loads counter = LAT-1, sets busy=1 and enters RUN.
- RUN:
  - The counter decrements each edge.
  - On the edge where counter==0: HI/LO are written, busy=0, state returns to IDLE.
  - Net result: busy is high for exactly LAT cycles, and new HI/LO are visible the cycle busy is first low.
- MTHI/MTLO with start in IDLE:
  - HI (or LO) = A at the next edge. Single cycle; busy is not raised.
- Start while busy=1:
  - Ignored completely: no latch, no MT write.
  - The hazard unit is required to prevent this. A bench checks that ignoring happens.
- Op 7, or op 6 without the feature: ignored.
- MULT: {HI,LO} = signed(A)*signed(B), 64-bit.
- MULTU: {HI,LO} = A*B, unsigned 64-bit.
- DIV:
  - LO = signed quotient truncated toward zero.
  - HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient into LO, unsigned remainder into HI.
- Divide by zero (B==0 latched): completes with full DIV_LAT timing, but HI/LO are left unchanged.
- Results are computed from the latched operands, so A/B changing during RUN has no effect.
- HILO_out is purely combinational from the current HI/LO. It does not forward a result still in flight.
- No flush input. The pipeline never cancels an accepted md instruction.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - md_op=6 (MADD) is legal, with MULT_LAT latency.
  - At completion, {HI,LO} = {HI,LO} + signed(A)*signed(B), modulo 2^64.
  - The HI/LO used are the values at completion time (unchanged during RUN).
- Undefined: md_op=6 is treated as op 7 (ignored) and no accumulator logic is built.

Test Plan:
- MULT: A=0xFFFFFFFE (-2), B=3, start in IDLE.
  - busy high for 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - rd_sel=1 gives HILO_out=0xFFFFFFFF.
- DIV: A=0xFFFFFFF9 (-7), B=2, busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU: A=7, B=0, completes after 10 cycles with HI/LO unchanged from a prior MTHI 0x11 / MTLO 0x22.
- Overlapping requests:
  - MULTU A=0xFFFFFFFF, B=0xFFFFFFFF is accepted.
  - A second start (MTLO A=0x5) is issued on cycle 2 of busy.
  - Result: HI=0xFFFFFFFE, LO=0x00000001, and the MTLO is ignored.
- Reset mid-op:
  - Start DIV, then drive reset=0 at cycle 4 between clock edges.
  - busy=0, HI=LO=0 immediately.
  - After release, the unit accepts MTHI A=0x1234 and HI=0x1234 next edge.
- MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADD A=1, B=1 gives HI=1, LO=0 after 5 cycles.
